ros_axil_regfile: RTL and testbench

ROS_AXIL_REGFILE -- requirements
Module: ros_axil_regfile

---
 rtl/ros_axil_pkg.sv | 36 +++
 rtl/ros_axil_regfile.sv | 146 ++++++++++++++
 tb/tb_ros_axil_regfile.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ros_axil_pkg.sv
// Shared definitions for the AXI4-Lite register file: response codes,
// register indices, FSM state encodings and the byte-lane merge helper.
package ros_axil_pkg;

  localparam int NUM_REGS = 4;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [1:0] REG0 = 2'd0;
  localparam logic [1:0] REG1 = 2'd1;
  localparam logic [1:0] REG2 = 2'd2;
  localparam logic [1:0] REG3 = 2'd3;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_HAVE_AW = 2'd1,
    W_HAVE_W  = 2'd2,
    W_RESP    = 2'd3
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int k = 0; k < 4; k++)
      if (strb[k]) res[8*k +: 8] = new_w[8*k +: 8];
    return res;
  endfunction

endpackage

// File: rtl/ros_axil_regfile.sv
// AXI4-Lite slave with four 32-bit registers and independent read/write FSMs.
// Define ROS_AXIL_WSTRB_EN to honour wstrb byte lanes; otherwise whole words are written.
module ros_axil_regfile
  import ros_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [NUM_REGS*32-1:0]          reg_q,
  output logic [NUM_REGS-1:0]             reg_wr_pulse
);

  wr_state_e   wst_q, wst_d;
  rd_state_e   rst_q, rst_d;
  logic        rdy_q;
  logic [1:0]  aw_idx_q;
  logic [31:0] w_data_q;
  logic [31:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pulse_q;
  logic [31:0] rdata_q;

  logic aw_held, w_held, bvalid, rvalid;
  logic aw_hs, w_hs, ar_hs, commit;
  logic [1:0]  c_idx;
  logic [31:0] c_data, wr_word;

  // Readies stay low through reset and rise on the first edge after release.
  assign aw_held = (wst_q == W_HAVE_AW);
  assign w_held  = (wst_q == W_HAVE_W);
  assign bvalid  = (wst_q == W_RESP);
  assign rvalid  = (rst_q == R_DATA);

  assign s00_axi_awready = rdy_q && !aw_held && !bvalid;
  assign s00_axi_wready  = rdy_q && !w_held && !bvalid;
  assign s00_axi_arready = rdy_q && !rvalid;
  assign s00_axi_bvalid  = bvalid;
  assign s00_axi_rvalid  = rvalid;
  assign s00_axi_bresp   = RESP_OKAY;
  assign s00_axi_rresp   = RESP_OKAY;
  assign s00_axi_rdata   = rdata_q;
  assign reg_wr_pulse    = pulse_q;

  assign aw_hs  = s00_axi_awvalid && s00_axi_awready;
  assign w_hs   = s00_axi_wvalid && s00_axi_wready;
  assign ar_hs  = s00_axi_arvalid && s00_axi_arready;
  assign commit = (aw_held || aw_hs) && (w_held || w_hs);

  assign c_idx  = aw_held ? aw_idx_q : s00_axi_awaddr[3:2];
  assign c_data = w_held ? w_data_q : s00_axi_wdata;

`ifdef ROS_AXIL_WSTRB_EN
  logic [3:0] w_strb_q;
  logic [3:0] c_strb;
  assign c_strb  = w_held ? w_strb_q : s00_axi_wstrb;
  assign wr_word = strb_merge(regs_q[c_idx], c_data, c_strb);

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset)
    if (s00_axi_areset) w_strb_q <= '0;
    else if (w_hs)      w_strb_q <= s00_axi_wstrb;

  logic unused_ok;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};
`else
  assign wr_word = c_data;

  logic unused_ok;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                       s00_axi_araddr[1:0], s00_axi_wstrb};
`endif

  always_comb begin
    wst_d = wst_q;
    case (wst_q)
      W_IDLE: begin
        if (aw_hs && w_hs) wst_d = W_RESP;
        else if (aw_hs)    wst_d = W_HAVE_AW;
        else if (w_hs)     wst_d = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)  wst_d = W_RESP;
      W_HAVE_W:  if (aw_hs) wst_d = W_RESP;
      W_RESP:    if (s00_axi_bready) wst_d = W_IDLE;
      default:   wst_d = W_IDLE;
    endcase
  end

  always_comb begin
    rst_d = rst_q;
    case (rst_q)
      R_IDLE:  if (ar_hs) rst_d = R_DATA;
      R_DATA:  if (s00_axi_rready) rst_d = R_IDLE;
      default: rst_d = R_IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      wst_q    <= W_IDLE;
      rst_q    <= R_IDLE;
      rdy_q    <= 1'b0;
      aw_idx_q <= '0;
      w_data_q <= '0;
      pulse_q  <= '0;
      rdata_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wst_q   <= wst_d;
      rst_q   <= rst_d;
      rdy_q   <= 1'b1;
      pulse_q <= '0;
      if (aw_hs) aw_idx_q <= s00_axi_awaddr[3:2];
      if (w_hs)  w_data_q <= s00_axi_wdata;
      if (commit) begin
        regs_q[c_idx]  <= wr_word;
        pulse_q[c_idx] <= 1'b1;
      end
      // Non-blocking read sees the pre-commit value on a same-edge write.
      if (ar_hs) rdata_q <= regs_q[s00_axi_araddr[3:2]];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_q[32*g +: 32] = regs_q[g];
  end

endmodule

// File: tb/tb_ros_axil_regfile.sv
// Randomized + directed bench for ros_axil_regfile against a queue-based transaction model.
module tb_ros_axil_regfile;
  import ros_axil_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   awaddr = '0, araddr = '0;
  logic [2:0]   awprot = '0, arprot = '0;
  logic         awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic         bready = 1'b0, rready = 1'b0;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         awready, wready, arready, bvalid, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [127:0] regq;
  logic [3:0]   pulse;

  always #5 clk = ~clk;

  ros_axil_regfile dut (
    .s00_axi_aclk(clk), .s00_axi_areset(rst),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid),
    .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid),
    .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready),
    .reg_q(regq), .reg_wr_pulse(pulse)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Transaction-level model: pending AW/W as queues, registers as a plain array.
  logic [31:0] m_regs [4];
  int          aq [$];
  logic [35:0] wq [$];
  bit          m_bv, m_rv, m_rdy;
  logic [31:0] m_rdata;
  logic [3:0]  m_pulse;
  bit          aw_fire, w_fire, ar_fire;
  bit          e_awr, e_wr, e_arr;
  int          c_idx;
  logic [35:0] c_wd;

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) m_regs[i] = '0;
      aq.delete(); wq.delete();
      m_bv = 0; m_rv = 0; m_rdy = 0; m_rdata = '0; m_pulse = '0;
    end
    e_awr = m_rdy && aq.size() == 0 && !m_bv;
    e_wr  = m_rdy && wq.size() == 0 && !m_bv;
    e_arr = m_rdy && !m_rv;
    chk("awready", awready, e_awr);
    chk("wready",  wready,  e_wr);
    chk("arready", arready, e_arr);
    chk("bvalid",  bvalid,  m_bv);
    chk("rvalid",  rvalid,  m_rv);
    chk("bresp",   bresp,   2'b00);
    chk("rresp",   rresp,   2'b00);
    chk("rdata",   rdata,   m_rdata);
    chk("reg_q",   regq,    {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
    chk("pulse",   pulse,   m_pulse);
    aw_fire = !rst && awvalid && e_awr;
    w_fire  = !rst && wvalid && e_wr;
    ar_fire = !rst && arvalid && e_arr;
    if (!rst) begin
      if (ar_fire) begin
        m_rdata = m_regs[araddr[3:2]];
        m_rv = 1;
      end else if (m_rv && rready) m_rv = 0;
      if (aw_fire) aq.push_back(int'(awaddr[3:2]));
      if (w_fire)  wq.push_back({wstrb, wdata});
      m_pulse = '0;
      if (aq.size() > 0 && wq.size() > 0) begin
        c_idx = aq.pop_front();
        c_wd  = wq.pop_front();
`ifdef ROS_AXIL_WSTRB_EN
        for (int k = 0; k < 4; k++)
          if (c_wd[32+k]) m_regs[c_idx][8*k +: 8] = c_wd[8*k +: 8];
`else
        m_regs[c_idx] = c_wd[31:0];
`endif
        m_pulse[c_idx] = 1'b1;
        m_bv = 1;
      end else if (m_bv && bready) m_bv = 0;
      m_rdy = 1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_aw(input logic [1:0] idx);
    bit ok = 0;
    awvalid = 1; awaddr = {idx, 2'($urandom_range(3))}; awprot = 3'($urandom);
    for (int i = 0; i < 40; i++) begin cyc(1); if (aw_fire) begin ok = 1; break; end end
    awvalid = 0;
    chk("aw_accept", ok, 1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    bit ok = 0;
    wvalid = 1; wdata = d; wstrb = s;
    for (int i = 0; i < 40; i++) begin cyc(1); if (w_fire) begin ok = 1; break; end end
    wvalid = 0;
    chk("w_accept", ok, 1);
  endtask

  task automatic wait_b();
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin cyc(1); if (!bvalid) begin ok = 1; break; end end
    chk("b_done", ok, 1);
  endtask

  task automatic write(input logic [1:0] idx, input logic [31:0] d, input logic [3:0] s);
    fork
      send_aw(idx);
      send_w(d, s);
    join
    wait_b();
  endtask

  task automatic read(input logic [1:0] idx, output logic [31:0] d);
    bit ok = 0;
    arvalid = 1; araddr = {idx, 2'($urandom_range(3))}; arprot = 3'($urandom);
    for (int i = 0; i < 40; i++) begin cyc(1); if (ar_fire) begin ok = 1; break; end end
    arvalid = 0;
    chk("ar_accept", ok, 1);
    chk("rvalid_lat1", rvalid, 1);
    d = rdata;
    cyc(1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  logic [31:0] rd;

  initial begin
    cyc(3);
    chk("rst_readies", {awready, wready, arready}, 3'b000);
    chk("rst_regq", regq, 128'd0);
    rst = 0;
    cyc(1);
    chk("readies_after_rst", {awready, wready, arready}, 3'b111);
    bready = 1; rready = 1;

    // four writes then four reads
    for (int i = 0; i < 4; i++) write(2'(i), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) begin
      read(2'(i), rd);
      chk("rd_seq", rd, 32'(i + 1));
    end
    chk("regq_seq", regq, 128'h00000004_00000003_00000002_00000001);

    // W three cycles ahead of AW
    wvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    cyc(1);
    chk("w_early_accept", w_fire, 1);
    wvalid = 0;
    cyc(2);
    awvalid = 1; awaddr = {REG2, 2'b00};
    cyc(1);
    awvalid = 0;
    chk("late_aw_pulse", pulse, 4'b0100);
    chk("late_aw_bvalid", bvalid, 1);
    cyc(1);
    chk("late_aw_pulse_off", pulse, 4'b0000);
    chk("late_aw_reg2", regq[95:64], 32'hDEADBEEF);

    // response back-pressure
    bready = 0;
    fork
      send_aw(REG3);
      send_w(32'h55, 4'hF);
    join
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("bp_bvalid", bvalid, 1);
      chk("bp_readies", {awready, wready}, 2'b00);
      chk("bp_no_pulse", pulse, 4'b0000);
    end
    bready = 1;
    cyc(1);
    chk("bp_release", bvalid, 0);

    // byte strobes
    write(REG0, 32'hFFFFFFFF, 4'hF);
    write(REG0, 32'h12345678, 4'b0101);
    read(REG0, rd);
`ifdef ROS_AXIL_WSTRB_EN
    chk("wstrb_merge", rd, 32'hFF34FF78);
`else
    chk("wstrb_ignored", rd, 32'h12345678);
`endif

    // read and write commit on the same edge
    awvalid = 1; awaddr = {REG1, 2'b00}; wvalid = 1; wdata = 32'hAA; wstrb = 4'hF;
    arvalid = 1; araddr = {REG1, 2'b00};
    cyc(1);
    chk("same_edge_fire", {aw_fire, w_fire, ar_fire}, 3'b111);
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("same_edge_old", rdata, 32'h2);
    cyc(2);
    read(REG1, rd);
    chk("same_edge_new", rd, 32'hAA);

    // reset with AW held and no W
    send_aw(REG2);
    rst = 1;
    cyc(1);
    chk("rst_mid_regq", regq, 128'd0);
    chk("rst_mid_bvalid", bvalid, 0);
    chk("rst_mid_pulse", pulse, 4'b0000);
    rst = 0;
    cyc(2);
    chk("rst_mid_nob", bvalid, 0);

    // randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      if (awvalid && aw_fire) awvalid = 0;
      if (wvalid && w_fire) wvalid = 0;
      if (arvalid && ar_fire) arvalid = 0;
      if (!awvalid && $urandom_range(2) == 0) begin
        awvalid = 1; awaddr = 4'($urandom); awprot = 3'($urandom);
      end
      if (!wvalid && $urandom_range(2) == 0) begin
        wvalid = 1; wdata = $urandom; wstrb = 4'($urandom);
      end
      if (!arvalid && $urandom_range(2) == 0) begin
        arvalid = 1; araddr = 4'($urandom); arprot = 3'($urandom);
      end
      bready = ($urandom_range(3) != 0);
      rready = ($urandom_range(3) != 0);
      rst = ($urandom_range(299) == 0);
      cyc(1);
    end
    rst = 0;
    awvalid = 0; wvalid = 0; arvalid = 0;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
